trackball_quad_gen: RTL and testbench



---
 rtl/trackball_pkg.sv | 18 +
 rtl/trackball_quad_gen_if.sv | 26 ++
 rtl/trackball_axis.sv | 103 ++++++++++
 rtl/trackball_quad_gen.sv | 56 +++++
 tb/tb_trackball_quad_gen.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/trackball_pkg.sv
// Shared types and constants for the trackball quadrature generator.
// Axis state encoding, default accumulator width and saturation limit.
package trackball_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      HIGH,
      LOW
   } axis_state_t;

   localparam int ACC_W_DEF = 10;

   function automatic int sat_lim(input int w);
      return (1 << (w - 1)) - 1;
   endfunction

endpackage

// File: rtl/trackball_quad_gen_if.sv
// Host motion inputs and trackball pulse outputs bundled together.
// master = host/driver side, slave = generator side.
interface trackball_quad_gen_if;

   logic              mouse_strobe;
   logic signed [8:0] mouse_dx;
   logic signed [8:0] mouse_dy;
   logic              inv_x;
   logic              inv_y;
   logic              tbHD;
   logic              tbHC;
   logic              tbVD;
   logic              tbVC;
   logic              busy;

   modport master (
      output mouse_strobe, mouse_dx, mouse_dy, inv_x, inv_y,
      input  tbHD, tbHC, tbVD, tbVC, busy
   );

   modport slave (
      input  mouse_strobe, mouse_dx, mouse_dy, inv_x, inv_y,
      output tbHD, tbHC, tbVD, tbVC, busy
   );

endinterface

// File: rtl/trackball_axis.sv
// One trackball axis: saturating pending-count accumulator replayed
// as a direction/clock step train, paced by the shared tick.
module trackball_axis
   import trackball_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              tick,
   input  logic              strobe,
   input  logic signed [8:0] delta,
   input  logic              inv,
   output logic              dir,
   output logic              sclk,
   output logic              active
);

   localparam int LIM = sat_lim(ACC_W);
   localparam logic signed [ACC_W:0] HI = (ACC_W + 1)'(LIM);
   localparam logic signed [ACC_W:0] LO = -HI;

   axis_state_t               state;
   logic signed [ACC_W-1:0]   p;
   logic signed [ACC_W-1:0]   p_nxt;
   logic signed [ACC_W:0]     d_ext;
   logic signed [ACC_W:0]     d;
   logic signed [ACC_W:0]     c;
   logic signed [ACC_W:0]     sum;
   logic                      p_nz;
   logic                      p_pos;
   logic                      take;

   assign p_nz  = |p;
   assign p_pos = ~p[ACC_W-1];

   // a step is only taken when pending motion still agrees with dir
   assign take = tick & p_nz & (dir == p_pos) &
                 ((state == SETUP) | (state == LOW));

   assign active = (state != IDLE) | p_nz;

   // merge new delta and consumed step, clamp to the symmetric limit
   always_comb begin
      d_ext = {{(ACC_W - 8){delta[8]}}, delta};
      d     = '0;
      if (strobe) d = inv ? -d_ext : d_ext;
      c     = '0;
      if (take) c = dir ? (ACC_W + 1)'(1) : '1;
      sum   = {p[ACC_W-1], p} + d - c;
      if (sum > HI)      p_nxt = HI[ACC_W-1:0];
      else if (sum < LO) p_nxt = LO[ACC_W-1:0];
      else               p_nxt = sum[ACC_W-1:0];
   end

   // step FSM; dir only moves while sclk is low
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         p     <= '0;
         dir   <= 1'b0;
         sclk  <= 1'b0;
      end else begin
         p <= p_nxt;
         if (tick) begin
            unique case (state)
               IDLE: begin
                  if (p_nz) begin
                     dir   <= p_pos;
                     state <= SETUP;
                  end
               end
               SETUP: begin
                  if (!p_nz) begin
                     state <= IDLE;
                  end else if (dir != p_pos) begin
                     dir <= p_pos;
                  end else begin
                     state <= HIGH;
                     sclk  <= 1'b1;
                  end
               end
               HIGH: begin
                  state <= LOW;
                  sclk  <= 1'b0;
               end
               LOW: begin
                  if (!p_nz) begin
                     state <= IDLE;
                  end else if (dir == p_pos) begin
                     state <= HIGH;
                     sclk  <= 1'b1;
                  end else begin
                     dir   <= p_pos;
                     state <= SETUP;
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: rtl/trackball_quad_gen.sv
// Host motion deltas to LETA-style trackball direction/clock pairs.
// Shared step tick, one independent engine per axis.
module trackball_quad_gen
   import trackball_pkg::*;
#(
   parameter int STEP_DIV = 40,
   parameter int ACC_W    = ACC_W_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   trackball_quad_gen_if.slave  bus
);

   localparam int CW = $clog2(STEP_DIV);

   logic [CW-1:0] cnt;
   logic          tick;
   logic          act_x;
   logic          act_y;

   assign tick = (cnt == CW'(STEP_DIV - 1));

   // free-running step divider shared by both axes
   always_ff @(posedge clk or posedge reset) begin
      if (reset)     cnt <= '0;
      else if (tick) cnt <= '0;
      else           cnt <= cnt + CW'(1);
   end

   trackball_axis #(.ACC_W(ACC_W)) u_x (
      .clk    (clk),
      .reset  (reset),
      .tick   (tick),
      .strobe (bus.mouse_strobe),
      .delta  (bus.mouse_dx),
      .inv    (bus.inv_x),
      .dir    (bus.tbHD),
      .sclk   (bus.tbHC),
      .active (act_x)
   );

   trackball_axis #(.ACC_W(ACC_W)) u_y (
      .clk    (clk),
      .reset  (reset),
      .tick   (tick),
      .strobe (bus.mouse_strobe),
      .delta  (bus.mouse_dy),
      .inv    (bus.inv_y),
      .dir    (bus.tbVD),
      .sclk   (bus.tbVC),
      .active (act_y)
   );

   assign bus.busy = act_x | act_y;

endmodule

// File: tb/tb_trackball_quad_gen.sv
// Self-checking bench: queue-of-steps scoreboard per axis, directed
// cases from the test plan plus randomized strobes.
module tb_trackball_quad_gen;

   localparam int DIV = 40;

   logic clk = 1'b0;
   logic reset;
   int   vectors = 0;
   int   misses = 0;
   int   cyc = 0;
   int   q[2][$];
   int   rise_t[2][$];
   logic prev_c[2];
   logic prev_d[2];
   logic prev_busy;
   logic m_c;
   logic m_d;
   int   t0;

   trackball_quad_gen_if bus ();

   trackball_quad_gen #(.STEP_DIV(DIV), .ACC_W(10)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1500000;
      $display("FAIL watchdog: time limit reached, vectors %0d", vectors);
      $fatal(1);
   end

   function automatic void check(input bit ok, input string name,
                                 input int act, input int req);
      vectors++;
      if (!ok) begin
         misses++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endfunction

   // pending motion as a queue of unit steps (+1/-1); opposite
   // steps cancel, length is capped at the saturation limit
   function automatic void model_add(input int ax, input int d);
      int s;
      int n;
      s = (d < 0) ? -1 : 1;
      n = (d < 0) ? -d : d;
      for (int i = 0; i < n; i++) begin
         if (q[ax].size() > 0 && q[ax][0] != s)
            void'(q[ax].pop_front());
         else if (q[ax].size() < 511)
            q[ax].push_back(s);
      end
   endfunction

   // monitor: pops one expected step per clock rise, checks dir
   always @(posedge clk) begin
      #1;
      if (reset) begin
         prev_c[0] = 1'b0;
         prev_c[1] = 1'b0;
         prev_d[0] = 1'b0;
         prev_d[1] = 1'b0;
         prev_busy = 1'b0;
      end else begin
         for (int a = 0; a < 2; a++) begin
            m_c = (a == 0) ? bus.tbHC : bus.tbVC;
            m_d = (a == 0) ? bus.tbHD : bus.tbVD;
            if (m_d != prev_d[a])
               check(!m_c && !prev_c[a], "dir_change_clk_low",
                     int'({m_c, prev_c[a]}), 0);
            if (m_c && !prev_c[a]) begin
               rise_t[a].push_back(cyc);
               check(q[a].size() > 0, "pulse_pending", q[a].size(), 1);
               if (q[a].size() > 0)
                  check(m_d == (q[a].pop_front() > 0), "pulse_dir",
                        int'(m_d), int'(!m_d));
            end
            prev_c[a] = m_c;
            prev_d[a] = m_d;
         end
         if (prev_busy && !bus.busy)
            check(q[0].size() + q[1].size() == 0, "idle_drained",
                  q[0].size() + q[1].size(), 0);
         prev_busy = bus.busy;
      end
   end

   task automatic do_strobe(input int dx, input int dy,
                            input bit ix, input bit iy);
      @(negedge clk);
      bus.mouse_dx     = 9'(dx);
      bus.mouse_dy     = 9'(dy);
      bus.inv_x        = ix;
      bus.inv_y        = iy;
      bus.mouse_strobe = 1'b1;
      @(posedge clk);
      #2;
      t0 = cyc;
      bus.mouse_strobe = 1'b0;
      model_add(0, ix ? -dx : dx);
      model_add(1, iy ? -dy : dy);
   endtask

   task automatic wait_idle(input int bound);
      int n = 0;
      while (bus.busy && n < bound) begin
         @(posedge clk);
         #3;
         n++;
      end
      check(!bus.busy, "idle_within_bound", n, bound);
   endtask

   task automatic wait_rises(input int ax, input int cnt, input int bound);
      int n = 0;
      while (rise_t[ax].size() < cnt && n < bound) begin
         @(posedge clk);
         #3;
         n++;
      end
      check(rise_t[ax].size() >= cnt, "rise_within_bound",
            rise_t[ax].size(), cnt);
   endtask

   task automatic check_gaps(input int ax, input int from);
      for (int i = from; i < rise_t[ax].size(); i++)
         check(rise_t[ax][i] - rise_t[ax][i-1] == 2 * DIV, "step_gap",
               rise_t[ax][i] - rise_t[ax][i-1], 2 * DIV);
   endtask

   task automatic clear_rises();
      rise_t[0].delete();
      rise_t[1].delete();
   endtask

   initial begin
      reset            = 1'b1;
      bus.mouse_strobe = 1'b0;
      bus.mouse_dx     = '0;
      bus.mouse_dy     = '0;
      bus.inv_x        = 1'b0;
      bus.inv_y        = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check({bus.tbHD, bus.tbHC, bus.tbVD, bus.tbVC, bus.busy} == 5'b0,
            "reset_outputs",
            int'({bus.tbHD, bus.tbHC, bus.tbVD, bus.tbVC, bus.busy}), 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (3 * DIV) @(posedge clk);
      #3;
      check(!bus.busy && rise_t[0].size() + rise_t[1].size() == 0,
            "quiet_after_reset", int'(bus.busy), 0);

      // +3 on X
      clear_rises();
      do_strobe(3, 0, 1'b0, 1'b0);
      wait_idle(20 * DIV);
      check(rise_t[0].size() == 3, "x3_count", rise_t[0].size(), 3);
      if (rise_t[0].size() > 0)
         check(rise_t[0][0] - t0 > DIV && rise_t[0][0] - t0 <= 2 * DIV,
               "x3_first_rise", rise_t[0][0] - t0, 2 * DIV);
      check_gaps(0, 1);
      check(rise_t[1].size() == 0, "x3_no_y", rise_t[1].size(), 0);

      // -2 on Y, inverted
      clear_rises();
      do_strobe(0, -2, 1'b0, 1'b1);
      wait_idle(20 * DIV);
      check(rise_t[1].size() == 2, "y_inv_count", rise_t[1].size(), 2);
      check(rise_t[0].size() == 0, "y_inv_no_x", rise_t[0].size(), 0);

      // -5 then -5 mid-train
      clear_rises();
      do_strobe(-5, 0, 1'b0, 1'b0);
      wait_rises(0, 1, 4 * DIV);
      do_strobe(-5, 0, 1'b0, 1'b0);
      wait_idle(40 * DIV);
      check(rise_t[0].size() == 10, "x10_count", rise_t[0].size(), 10);
      check_gaps(0, 1);

      // +4 then -6 after the second rise
      clear_rises();
      do_strobe(4, 0, 1'b0, 1'b0);
      wait_rises(0, 2, 8 * DIV);
      do_strobe(-6, 0, 1'b0, 1'b0);
      wait_idle(40 * DIV);
      check(rise_t[0].size() == 6, "rev_count", rise_t[0].size(), 6);
      if (rise_t[0].size() >= 3)
         check(rise_t[0][2] - rise_t[0][1] == 3 * DIV, "rev_setup_gap",
               rise_t[0][2] - rise_t[0][1], 3 * DIV);
      if (rise_t[0].size() >= 4)
         check_gaps(0, 3);

      // saturation: three back-to-back +255
      clear_rises();
      do_strobe(255, 0, 1'b0, 1'b0);
      do_strobe(255, 0, 1'b0, 1'b0);
      do_strobe(255, 0, 1'b0, 1'b0);
      wait_idle(1100 * DIV);
      check(rise_t[0].size() == 511, "sat_count", rise_t[0].size(), 511);

      // async reset while clock is high with 7 pending
      clear_rises();
      do_strobe(10, 0, 1'b0, 1'b0);
      wait_rises(0, 3, 10 * DIV);
      check(bus.tbHC == 1'b1, "mid_train_high", int'(bus.tbHC), 1);
      #1;
      reset = 1'b1;
      #1;
      check({bus.tbHD, bus.tbHC, bus.tbVD, bus.tbVC, bus.busy} == 5'b0,
            "async_reset_outputs",
            int'({bus.tbHD, bus.tbHC, bus.tbVD, bus.tbVC, bus.busy}), 0);
      q[0].delete();
      q[1].delete();
      clear_rises();
      @(negedge clk);
      reset = 1'b0;
      repeat (10 * DIV) @(posedge clk);
      #3;
      check(rise_t[0].size() == 0 && !bus.busy, "no_pulse_after_reset",
            rise_t[0].size(), 0);

      // randomized strobes, arbitrary timing relative to the tick
      for (int it = 0; it < 25; it++) begin
         do_strobe($urandom_range(0, 12) - 6, $urandom_range(0, 12) - 6,
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 120)) @(posedge clk);
         if (q[0].size() > 40 || q[1].size() > 40)
            wait_idle(200 * DIV);
      end
      wait_idle(200 * DIV);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
      $finish;
   end

endmodule
